mem_arbiter: RTL

//  Downstream consumer of the request unit: takes its iREN/dREN/dWEN strobes plus

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win over instruction fetches, with a watchdog
// that aborts accesses the RAM never completes and a halt that parks the bus for good.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic [31:0] ramaddr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramstore,
    output logic        busy,
    output logic        mem_err
);

    // state  | meaning
    // IDLE   | no grant; picks data over instruction on the next edge
    // DACC   | data read/write owns the RAM bus
    // IACC   | instruction fetch owns the RAM bus
    // HALTED | parked until reset; requests ignored
    typedef enum logic [1:0] {IDLE, DACC, IACC, HALTED} state_t;

    localparam logic [1:0]       RS_ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             halt_seen;
    logic             mask_d;
    logic             mask_i;

    logic in_d, in_i, d_own, owner, access, hit, expire, dreq, ireq;

    assign in_d   = (state == DACC);
    assign in_i   = (state == IACC);
    assign d_own  = dREN | dWEN;
    assign owner  = in_d ? d_own : iREN;
    assign access = (ramstate == RS_ACCESS);

    assign dhit   = in_d & d_own & access;
    assign ihit   = in_i & iREN & access;
    assign hit    = dhit | ihit;
    assign dload  = dhit ? ramload : 32'h0;
    assign iload  = ihit ? ramload : 32'h0;

    assign ramaddr  = in_d ? daddr : (in_i ? iaddr : 32'h0);
    assign ramREN   = (in_d & dREN) | in_i;
    assign ramWEN   = in_d & dWEN;
    assign ramstore = in_d ? dstore : 32'h0;
    assign busy     = in_d | in_i;

    // Watchdog is a down-counter: loaded on grant, terminal count at zero.
    assign expire = busy & owner & ~access & (cnt == '0);

    // The requester that just hit may still be asserting for one cycle; ignore it once.
    assign dreq = d_own & ~mask_d;
    assign ireq = iREN & ~mask_i;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_err   <= 1'b0;
            halt_seen <= 1'b0;
            mask_d    <= 1'b0;
            mask_i    <= 1'b0;
        end else begin
            mask_d <= dhit;
            mask_i <= ihit;
            unique case (state)
                IDLE: begin
                    halt_seen <= 1'b0;
                    if (halt) begin
                        state <= HALTED;
                    end else if (dreq) begin
                        state <= DACC;
                        cnt   <= CNT_LOAD;
                    end else if (ireq) begin
                        state <= IACC;
                        cnt   <= CNT_LOAD;
                    end
                end
                DACC, IACC: begin
                    if (halt)
                        halt_seen <= 1'b1;
                    if (!owner || hit || expire)
                        state <= (halt || halt_seen) ? HALTED : IDLE;
                    else if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    if (expire)
                        mem_err <= 1'b1;
                end
                HALTED: state <= HALTED;
            endcase
        end
    end

endmodule
